btn_action_encoder: RTL and testbench

- Parametrised successor to the minesweeper click encoder.
- Turns raw board buttons (C, U, R, D, L) into one registered 3-bit action code for the game controller.
- Adds synchroniser/debounce and timer-based double-click detection on btnC.
- Holds each action with a valid/ack handshake and a sticky dropped-event flag.

---
 rtl/btn_action_encoder.sv | 186 ++++++++++++++++++
 tb/tb_btn_action_encoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_action_encoder.sv
// Debounced five-button front end that encodes presses (with optional double-click on btnC)
// into a single held action code, handshaked with valid/ack and a sticky dropped flag.
module btn_action_encoder #(
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int DBL_WINDOW_CYCLES = 20,
    parameter int CNT_W             = 16
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       btnC,
    input  logic       btnU,
    input  logic       btnR,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       dbl_en,
    input  logic       ack,
    output logic [2:0] action,
    output logic       valid,
    output logic       dropped
);

    localparam logic [2:0] ACT_NONE   = 3'b000;
    localparam logic [2:0] ACT_SINGLE = 3'b001;
    localparam logic [2:0] ACT_DOUBLE = 3'b010;
    localparam logic [2:0] ACT_U      = 3'b100;
    localparam logic [2:0] ACT_R      = 3'b101;
    localparam logic [2:0] ACT_D      = 3'b110;
    localparam logic [2:0] ACT_L      = 3'b111;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(DBL_WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {IDLE, WAIT2} state_t;

    // Bit order: 0=C, 1=U, 2=R, 3=D, 4=L
    logic [4:0]       w_raw;
    logic [4:0]       r_sync1;
    logic [4:0]       r_sync2;
    logic [4:0]       r_level;
    logic [4:0]       r_levelPrev;
    logic [CNT_W-1:0] r_dbCnt [5];
    logic             r_dblSync1;
    logic             r_dblSync2;
    logic [4:0]       w_press;

    logic [CNT_W-1:0] r_winCnt;
    logic             w_winExpire;
    state_t           r_state;
    state_t           w_nextState;

    logic             w_dirAny;
    logic             w_dirMulti;
    logic [2:0]       w_dirCode;
    logic             w_cEmit;
    logic [2:0]       w_cCode;
    logic             w_cDrop;
    logic             w_emit;
    logic [2:0]       w_code;
    logic             w_dropNow;

    assign w_raw   = {btnL, btnD, btnR, btnU, btnC};
    assign w_press = r_level & ~r_levelPrev;

    // Debounce counter flips the level once DEBOUNCE_CYCLES differing samples are seen in a row
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_level     <= '0;
            r_levelPrev <= '0;
            r_dblSync1  <= 1'b0;
            r_dblSync2  <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_dbCnt[i] <= '0;
            end
        end else begin
            r_sync1     <= w_raw;
            r_sync2     <= r_sync1;
            r_levelPrev <= r_level;
            r_dblSync1  <= dbl_en;
            r_dblSync2  <= r_dblSync1;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (r_dbCnt[i] >= DB_LAST) begin
                    r_level[i] <= ~r_level[i];
                    r_dbCnt[i] <= '0;
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_dirAny   = |w_press[4:1];
        w_dirMulti = |(w_press[4:1] & (w_press[4:1] - 4'd1));
        w_dirCode  = ACT_NONE;
        if (w_press[1])      w_dirCode = ACT_U;
        else if (w_press[2]) w_dirCode = ACT_R;
        else if (w_press[3]) w_dirCode = ACT_D;
        else if (w_press[4]) w_dirCode = ACT_L;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state  <= IDLE;
            r_winCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE)
                r_winCnt <= '0;
            else if (r_winCnt != CNT_MAX)
                r_winCnt <= r_winCnt + 1'b1;
        end
    end

    assign w_winExpire = (r_winCnt >= WIN_LAST);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:  if (r_dblSync2 && w_press[0]) w_nextState = WAIT2;
            WAIT2: if (!r_dblSync2 || w_press[0] || w_dirAny || w_winExpire) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // A pending first click always resolves to a single click unless a second C arrives in time
    always_comb begin
        w_cEmit = 1'b0;
        w_cCode = ACT_NONE;
        w_cDrop = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_dblSync2 && w_press[0]) begin
                    w_cEmit = 1'b1;
                    w_cCode = ACT_SINGLE;
                end
            end
            WAIT2: begin
                if (!r_dblSync2) begin
                    w_cEmit = 1'b1;
                    w_cCode = ACT_SINGLE;
                    w_cDrop = w_press[0];
                end else if (w_press[0]) begin
                    w_cEmit = 1'b1;
                    w_cCode = ACT_DOUBLE;
                end else if (w_dirAny || w_winExpire) begin
                    w_cEmit = 1'b1;
                    w_cCode = ACT_SINGLE;
                end
            end
            default: ;
        endcase
    end

    assign w_emit    = w_cEmit | w_dirAny;
    assign w_code    = w_cEmit ? w_cCode : w_dirCode;
    assign w_dropNow = w_dirMulti | (w_cEmit & w_dirAny) | w_cDrop | (w_emit & valid & ~ack);

    // A held action blocks new ones until acked; losses in the ack cycle itself still count
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            action  <= ACT_NONE;
            valid   <= 1'b0;
            dropped <= 1'b0;
        end else begin
            if (!valid || ack) begin
                if (w_emit) begin
                    action <= w_code;
                    valid  <= 1'b1;
                end else begin
                    action <= ACT_NONE;
                    valid  <= 1'b0;
                end
            end
            if (valid && ack)
                dropped <= w_dropNow;
            else
                dropped <= dropped | w_dropNow;
        end
    end

endmodule

// File: tb/tb_btn_action_encoder.sv
// Directed bench for btn_action_encoder with DEBOUNCE_CYCLES=4 and DBL_WINDOW_CYCLES=20;
// cycle numbers in comments count edges after the raw input change.
module tb_btn_action_encoder;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       btnC = 1'b0, btnU = 1'b0, btnR = 1'b0, btnD = 1'b0, btnL = 1'b0;
    logic       dbl_en = 1'b0;
    logic       ack = 1'b0;
    logic [2:0] action;
    logic       valid;
    logic       dropped;
    int         checks = 0;
    int         errors = 0;

    btn_action_encoder #(
        .DEBOUNCE_CYCLES(4),
        .DBL_WINDOW_CYCLES(20),
        .CNT_W(16)
    ) dut (
        .clk(clk), .clear(clear),
        .btnC(btnC), .btnU(btnU), .btnR(btnR), .btnD(btnD), .btnL(btnL),
        .dbl_en(dbl_en), .ack(ack),
        .action(action), .valid(valid), .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        {btnC, btnU, btnR, btnD, btnL, ack} = '0;
        clear = 1'b1;
        step(2);
        clear = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        step(2);
        checks++; if (action !== 3'b000) begin errors++; $display("[TB] FAIL reset_action got %b expected 000", action); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", valid); end
        checks++; if (dropped !== 1'b0) begin errors++; $display("[TB] FAIL reset_dropped got %b expected 0", dropped); end
        clear = 1'b0;
        step(1);
    endtask

    task automatic test_single_u();
        btnU = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL u_early_valid cycle %0d got %b expected 0", k, valid); end
        end
        step(1);
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL u_valid got %b expected 1", valid); end
        checks++; if (action !== 3'b100) begin errors++; $display("[TB] FAIL u_action got %b expected 100", action); end
        checks++; if (dropped !== 1'b0) begin errors++; $display("[TB] FAIL u_dropped got %b expected 0", dropped); end
        step(3);
        btnU = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            checks++; if (valid !== 1'b1 || action !== 3'b100) begin errors++; $display("[TB] FAIL u_hold got %b/%b expected 1/100", valid, action); end
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++; if (valid !== 1'b0 || action !== 3'b000) begin errors++; $display("[TB] FAIL u_ack got %b/%b expected 0/000", valid, action); end
        step(8);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL u_release_valid got %b expected 0", valid); end
    endtask

    task automatic test_glitch();
        btnR = 1'b1;
        step(3);
        btnR = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            checks++; if (valid !== 1'b0 || action !== 3'b000) begin errors++; $display("[TB] FAIL glitch got %b/%b expected 0/000", valid, action); end
        end
    endtask

    task automatic test_double_click();
        dbl_en = 1'b1;
        step(4);
        // First debounced edge at 6, second at 16 -> 010 valid at 17
        btnC = 1'b1;
        step(4);
        btnC = 1'b0;
        step(6);
        btnC = 1'b1;
        step(4);
        btnC = 1'b0;
        step(2);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL dbl_early got %b expected 0", valid); end
        step(1);
        checks++; if (valid !== 1'b1 || action !== 3'b010) begin errors++; $display("[TB] FAIL dbl_action got %b/%b expected 1/010", valid, action); end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(10);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL dbl_after got %b expected 0", valid); end
    endtask

    task automatic test_window_timeout();
        // Debounced edges at 6 and 31: timeouts give 001 at 27 and at 52
        btnC = 1'b1;
        step(4);
        btnC = 1'b0;
        step(21);
        btnC = 1'b1;
        step(1);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL tmo1_early got %b expected 0", valid); end
        step(1);
        checks++; if (valid !== 1'b1 || action !== 3'b001) begin errors++; $display("[TB] FAIL tmo1_action got %b/%b expected 1/001", valid, action); end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL tmo1_ack got %b expected 0", valid); end
        step(1);
        btnC = 1'b0;
        step(22);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL tmo2_early got %b expected 0", valid); end
        step(1);
        checks++; if (valid !== 1'b1 || action !== 3'b001) begin errors++; $display("[TB] FAIL tmo2_action got %b/%b expected 1/001", valid, action); end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(6);
    endtask

    task automatic test_c_then_l();
        // C debounced at 6 opens the window; L debounced at 11 forces 001 at 12
        btnC = 1'b1;
        step(4);
        btnC = 1'b0;
        step(1);
        btnL = 1'b1;
        step(6);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL cl_early got %b expected 0", valid); end
        step(1);
        checks++; if (valid !== 1'b1 || action !== 3'b001) begin errors++; $display("[TB] FAIL cl_action got %b/%b expected 1/001", valid, action); end
        checks++; if (dropped !== 1'b1) begin errors++; $display("[TB] FAIL cl_dropped got %b expected 1", dropped); end
        btnL = 1'b0;
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++; if (valid !== 1'b0 || dropped !== 1'b0) begin errors++; $display("[TB] FAIL cl_ack got %b/%b expected 0/0", valid, dropped); end
        for (int k = 0; k < 25; k++) begin
            step(1);
            checks++; if (action === 3'b111 || valid !== 1'b0) begin errors++; $display("[TB] FAIL cl_no_l got %b/%b expected 0/000", valid, action); end
        end
    endtask

    task automatic test_dir_priority();
        dbl_en = 1'b0;
        step(3);
        btnD = 1'b1;
        btnL = 1'b1;
        step(7);
        checks++; if (valid !== 1'b1 || action !== 3'b110) begin errors++; $display("[TB] FAIL dl_action got %b/%b expected 1/110", valid, action); end
        checks++; if (dropped !== 1'b1) begin errors++; $display("[TB] FAIL dl_dropped got %b expected 1", dropped); end
        btnD = 1'b0;
        btnL = 1'b0;
        // U raw at 8 debounces at 14 while 110 is still held
        step(1);
        btnU = 1'b1;
        step(4);
        btnU = 1'b0;
        step(3);
        checks++; if (valid !== 1'b1 || action !== 3'b110) begin errors++; $display("[TB] FAIL blocked_u got %b/%b expected 1/110", valid, action); end
        checks++; if (dropped !== 1'b1) begin errors++; $display("[TB] FAIL blocked_dropped got %b expected 1", dropped); end
        // Second U raw at 19 debounces at 25; ack rides the same cycle
        step(4);
        btnU = 1'b1;
        step(4);
        btnU = 1'b0;
        step(2);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++; if (valid !== 1'b1 || action !== 3'b100) begin errors++; $display("[TB] FAIL ack_new got %b/%b expected 1/100", valid, action); end
        checks++; if (dropped !== 1'b0) begin errors++; $display("[TB] FAIL ack_new_dropped got %b expected 0", dropped); end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++; if (valid !== 1'b0 || action !== 3'b000) begin errors++; $display("[TB] FAIL ack_final got %b/%b expected 0/000", valid, action); end
    endtask

    task automatic test_clear_wait2();
        dbl_en = 1'b1;
        step(3);
        btnU = 1'b1;
        step(4);
        btnU = 1'b0;
        step(3);
        checks++; if (valid !== 1'b1 || action !== 3'b100) begin errors++; $display("[TB] FAIL clr_pre got %b/%b expected 1/100", valid, action); end
        btnC = 1'b1;
        step(4);
        btnC = 1'b0;
        step(9);
        #2 clear = 1'b1;
        #1;
        checks++; if (action !== 3'b000 || valid !== 1'b0 || dropped !== 1'b0) begin errors++; $display("[TB] FAIL clr_async got %b/%b/%b expected 000/0/0", action, valid, dropped); end
        step(2);
        clear = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(1);
            checks++; if (valid !== 1'b0 || action !== 3'b000) begin errors++; $display("[TB] FAIL clr_after got %b/%b expected 0/000", valid, action); end
        end
    endtask

    initial begin
        test_reset();
        test_single_u();
        doReset();
        test_glitch();
        doReset();
        test_double_click();
        test_window_timeout();
        doReset();
        dbl_en = 1'b1;
        step(3);
        test_c_then_l();
        doReset();
        test_dir_priority();
        doReset();
        test_clear_wait2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
